alu_multiciclo: RTL and testbench

ALU_MULTICICLO -- requirements
Module: alu_multiciclo

---
 rtl/alu_multiciclo.sv | 121 ++++++++++++
 tb/tb_alu_multiciclo.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu_multiciclo.sv
// Multicycle ALU: single-cycle logic/arith ops, shifts done one bit per cycle.
// Registered result with zero flag; unsupported opcodes complete with o_Error.
module alu_multiciclo #(
  parameter int NBITS  = 32,
  parameter int ALUOP  = 4,
  parameter int NSHAMT = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [ALUOP-1:0]  i_ALUOp,
  input  logic [NBITS-1:0]  i_A,
  input  logic [NBITS-1:0]  i_B,
  input  logic [NSHAMT-1:0] i_Shamt,
  output logic              o_Ready,
  output logic              o_Valid,
  output logic [NBITS-1:0]  o_Result,
  output logic              o_Zero,
  output logic              o_Error
);

  localparam logic [ALUOP-1:0] OP_AND = ALUOP'(4'b0000);
  localparam logic [ALUOP-1:0] OP_OR  = ALUOP'(4'b0001);
  localparam logic [ALUOP-1:0] OP_ADD = ALUOP'(4'b0010);
  localparam logic [ALUOP-1:0] OP_SLL = ALUOP'(4'b0011);
  localparam logic [ALUOP-1:0] OP_SRL = ALUOP'(4'b0100);
  localparam logic [ALUOP-1:0] OP_SUB = ALUOP'(4'b0110);
  localparam logic [ALUOP-1:0] OP_SLT = ALUOP'(4'b0111);
  localparam logic [ALUOP-1:0] OP_NOR = ALUOP'(4'b1100);
  localparam logic [ALUOP-1:0] OP_XOR = ALUOP'(4'b1101);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [NBITS-1:0]  sh_q, sh_d, sh_nx;
  logic [NSHAMT-1:0] cnt_q, cnt_d;
  logic              left_q, left_d;
  logic [NBITS-1:0]  res_d;
  logic              valid_d, err_d;
  logic              is_shift;

  assign o_Ready  = (state_q == IDLE);
  assign is_shift = (i_ALUOp == OP_SLL) || (i_ALUOp == OP_SRL);
  assign sh_nx    = left_q ? (sh_q << 1) : (sh_q >> 1);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    res_d   = o_Result;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (is_shift && (i_Shamt != '0)) begin
            state_d = SHIFT;
            sh_d    = i_B;
            cnt_d   = i_Shamt;
            left_d  = (i_ALUOp == OP_SLL);
          end else begin
            valid_d = 1'b1;
            case (i_ALUOp)
              OP_ADD:  res_d = i_A + i_B;
              OP_SUB:  res_d = i_A - i_B;
              OP_AND:  res_d = i_A & i_B;
              OP_OR:   res_d = i_A | i_B;
              OP_NOR:  res_d = ~(i_A | i_B);
              OP_XOR:  res_d = i_A ^ i_B;
              OP_SLT:  res_d = ($signed(i_A) < $signed(i_B)) ? NBITS'(1) : '0;
              // only reachable with a zero shift amount
              OP_SLL,
              OP_SRL:  res_d = i_B;
              default: begin
                res_d = '0;
                err_d = 1'b1;
              end
            endcase
          end
        end
      end
      SHIFT: begin
        sh_d  = sh_nx;
        cnt_d = cnt_q - NSHAMT'(1);
        if (cnt_q == NSHAMT'(1)) begin
          state_d = IDLE;
          res_d   = sh_nx;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sh_q     <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      o_Result <= '0;
      o_Zero   <= 1'b1;
      o_Valid  <= 1'b0;
      o_Error  <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      o_Result <= res_d;
      o_Zero   <= (res_d == '0);
      o_Valid  <= valid_d;
      o_Error  <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed bench for alu_multiciclo: hand-computed vectors checked with immediate assertions.
module tb_alu_multiciclo;
  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [3:0]  i_ALUOp;
  logic [31:0] i_A, i_B;
  logic [4:0]  i_Shamt;
  logic        o_Ready, o_Valid, o_Zero, o_Error;
  logic [31:0] o_Result;

  int n_vec = 0;
  int n_err = 0;
  int lat, busy, seen;

  alu_multiciclo #(.NBITS(32), .ALUOP(4), .NSHAMT(5)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_ALUOp(i_ALUOp),
    .i_A(i_A), .i_B(i_B), .i_Shamt(i_Shamt), .o_Ready(o_Ready), .o_Valid(o_Valid),
    .o_Result(o_Result), .o_Zero(o_Zero), .o_Error(o_Error)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh);
    i_valid = 1'b1; i_ALUOp = op; i_A = a; i_B = b; i_Shamt = sh;
  endtask

  // Called one cycle after acceptance; returns latency and number of busy cycles seen.
  task automatic wait_done(output int l, output int b);
    l = 1; b = 0;
    while (!o_Valid && l < 40) begin
      if (!o_Ready) b++;
      step();
      l++;
    end
  endtask

  initial begin
    i_reset = 1'b0; i_valid = 1'b0; i_ALUOp = 4'h0; i_A = '0; i_B = '0; i_Shamt = '0;
    #12;
    check("rst_ready",  {31'd0, o_Ready}, 32'd1);
    check("rst_valid",  {31'd0, o_Valid}, 32'd0);
    check("rst_error",  {31'd0, o_Error}, 32'd0);
    check("rst_result", o_Result, 32'd0);
    check("rst_zero",   {31'd0, o_Zero}, 32'd1);
    step();
    i_reset = 1'b1;

    // ADD wraps to zero; accepted on the first edge after release
    req(4'b0010, 32'hFFFF_FFFF, 32'h1, 5'd0);
    step();
    check("add_res",   o_Result, 32'h0);
    check("add_zero",  {31'd0, o_Zero}, 32'd1);
    check("add_valid", {31'd0, o_Valid}, 32'd1);
    check("add_err",   {31'd0, o_Error}, 32'd0);

    req(4'b0111, 32'hFFFF_FFFE, 32'h1, 5'd0);
    step();
    check("slt_res", o_Result, 32'h1);
    req(4'b0110, 32'h3, 32'h5, 5'd0);
    step();
    check("sub_res",  o_Result, 32'hFFFF_FFFE);
    check("sub_zero", {31'd0, o_Zero}, 32'd0);

    // back-to-back logic ops
    req(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0); step();
    check("and_res", o_Result, 32'hF000_F000);
    check("and_vld", {31'd0, o_Valid}, 32'd1);
    req(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0); step();
    check("or_res",  o_Result, 32'hFFF0_FFF0);
    check("or_vld",  {31'd0, o_Valid}, 32'd1);
    req(4'b1101, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0); step();
    check("xor_res", o_Result, 32'h0FF0_0FF0);
    check("xor_vld", {31'd0, o_Valid}, 32'd1);
    req(4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0); step();
    check("nor_res", o_Result, 32'h000F_000F);
    check("nor_vld", {31'd0, o_Valid}, 32'd1);
    i_valid = 1'b0; step();
    check("idle_vld",  {31'd0, o_Valid}, 32'd0);
    check("hold_res",  o_Result, 32'h000F_000F);
    check("hold_zero", {31'd0, o_Zero}, 32'd0);

    // unsupported opcode
    req(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7); step();
    check("bad_res", o_Result, 32'h0);
    check("bad_err", {31'd0, o_Error}, 32'd1);
    check("bad_vld", {31'd0, o_Valid}, 32'd1);
    i_valid = 1'b0; step();
    check("bad_err_clr", {31'd0, o_Error}, 32'd0);
    check("bad_vld_clr", {31'd0, o_Valid}, 32'd0);

    // SLL by 31, with a request held during busy that must be ignored
    req(4'b0011, 32'h0, 32'h1, 5'd31); step();
    req(4'b0010, 32'h5, 32'h5, 5'd0);
    wait_done(lat, busy);
    i_valid = 1'b0;
    check("sll_lat",   lat, 32'd32);
    check("sll_busy",  busy, 32'd31);
    check("sll_res",   o_Result, 32'h8000_0000);
    check("sll_vld",   {31'd0, o_Valid}, 32'd1);
    check("sll_ready", {31'd0, o_Ready}, 32'd1);
    step();
    check("sll_after", o_Result, 32'h8000_0000);
    check("sll_vld_clr", {31'd0, o_Valid}, 32'd0);

    // SRL by 4
    req(4'b0100, 32'h0, 32'hF000_0000, 5'd4); step();
    i_valid = 1'b0;
    wait_done(lat, busy);
    check("srl_lat", lat, 32'd5);
    check("srl_res", o_Result, 32'h0F00_0000);

    // zero shift amount completes in one cycle
    req(4'b0011, 32'h0, 32'h0000_1234, 5'd0); step();
    check("sll0_res", o_Result, 32'h0000_1234);
    check("sll0_vld", {31'd0, o_Valid}, 32'd1);

    // reset mid-SRL aborts the operation
    req(4'b0100, 32'h0, 32'h8000_0000, 5'd10); step();
    i_valid = 1'b0;
    step(); step(); step();
    i_reset = 1'b0;
    #1;
    check("abort_ready", {31'd0, o_Ready}, 32'd1);
    check("abort_vld",   {31'd0, o_Valid}, 32'd0);
    check("abort_res",   o_Result, 32'h0);
    check("abort_zero",  {31'd0, o_Zero}, 32'd1);
    step();
    i_reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (o_Valid) seen++;
    end
    check("abort_no_vld", seen, 32'd0);
    req(4'b0010, 32'h2, 32'h2, 5'd0); step();
    i_valid = 1'b0;
    check("post_add_res", o_Result, 32'h4);
    check("post_add_vld", {31'd0, o_Valid}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
